// File: rtl/kd_pkg.sv
// kd-tree load controller shared definitions.
// Holds the tree/frame geometry, the derived word counts of each load
// section, the packed patch type and the load sequencer state encoding.
package kd_pkg;

   localparam int DATA_WIDTH  = 11;
   localparam int IDX_WIDTH   = 9;
   localparam int PATCH_SIZE  = 5;
   localparam int LEAF_SIZE   = 8;
   localparam int NUM_LEAVES  = 64;
   localparam int NUM_QUERYS  = 494;
   localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES);
   localparam int QUERY_ADDRW = $clog2(NUM_QUERYS);
   localparam int SLOT_W      = $clog2(LEAF_SIZE);

   localparam int WORDS_PER_LEAF_PATCH = PATCH_SIZE + 1;
   localparam int NODE_WORDS  = 2 * (NUM_LEAVES - 1);
   localparam int LEAF_WORDS  = NUM_LEAVES * LEAF_SIZE * WORDS_PER_LEAF_PATCH;
   localparam int QUERY_WORDS = NUM_QUERYS * PATCH_SIZE;

   typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

   typedef enum logic [2:0] {
      IDLE,
      NODES,
      LEAVES,
      QUERY,
      DONE
   } state_t;

endpackage

// File: rtl/patch_assembler.sv
// Patch assembler: collects FIFO words of one record into a patch.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        a word is accepted this cycle
//   clear       drop any partial record (wins over push)
//   nwords      words per record (patch words plus optional trailer)
//   data        incoming word
//   patch       assembled patch, including the word pushed this cycle
//   last        this push completes the record
// Only the first PATCH_SIZE words of a record enter the shift register;
// a trailing word (leaf index) is left for the caller to capture.
module patch_assembler
   import kd_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic                             clear,
   input  logic [2:0]                       nwords,
   input  logic [DATA_WIDTH-1:0]            data,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch,
   output logic                             last
);

   patch_t     sreg;
   patch_t     sreg_nxt;
   logic [2:0] cnt;
   logic       shift_en;

   assign shift_en = push && (cnt < 3'(PATCH_SIZE));
   assign last     = push && (cnt == (nwords - 3'd1));

   // New words enter at the top so word 0 ends up in the LSBs.
   assign sreg_nxt = shift_en ? {data, sreg[PATCH_SIZE-1:1]} : sreg;
   assign patch    = sreg_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (clear) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (push) begin
         sreg <= sreg_nxt;
         cnt  <= last ? 3'd0 : cnt + 3'd1;
      end
   end

endmodule

// File: rtl/kdtree_load_ctrl.sv
// kd-tree load controller: after load_kdtree, drains the input FIFO into
// the internal-node registers, the leaf memory and the query memory, one
// wide write per assembled record.
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   load_kdtree                 start/restart pulse
//   in_fifo_rempty_n/rdata/deq  FWFT FIFO head and pop
//   node_*                      node write: number, split dim, split value
//   leaf_*                      leaf patch write: leaf, slot, data, index
//   query_*                     query patch write: number, data
//   busy                        sequence in progress
//   kdtree_loaded               sticky, all nodes and leaves written
//   queries_loaded              sticky, all queries written
//   cfg_err                     sticky, a node split dim was out of range
//
// state  | meaning
// IDLE   | after reset, no pops
// NODES  | idx/median word pairs -> node registers
// LEAVES | 5 data + 1 index words per patch -> leaf memory
// QUERY  | 5 data words per patch -> query memory
// DONE   | everything loaded, no pops
module kdtree_load_ctrl
   import kd_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load_kdtree,
   input  logic                             in_fifo_rempty_n,
   input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
   output logic                             in_fifo_deq,
   output logic                             node_wen,
   output logic [LEAF_ADDRW-1:0]            node_waddr,
   output logic [2:0]                       node_idx,
   output logic [DATA_WIDTH-1:0]            node_median,
   output logic                             leaf_wen,
   output logic [LEAF_ADDRW-1:0]            leaf_waddr,
   output logic [SLOT_W-1:0]                leaf_slot,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wpatch,
   output logic [IDX_WIDTH-1:0]             leaf_widx,
   output logic                             query_wen,
   output logic [QUERY_ADDRW-1:0]           query_waddr,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wpatch,
   output logic                             busy,
   output logic                             kdtree_loaded,
   output logic                             queries_loaded,
   output logic                             cfg_err
);

   state_t                          state;
   state_t                          state_nxt;
   logic                            take;
   logic                            asm_push;
   logic [2:0]                      asm_nwords;
   logic [PATCH_SIZE*DATA_WIDTH-1:0] asm_patch;
   logic                            asm_last;
   logic                            node_phase;
   logic [2:0]                      idx_hold;
   logic [LEAF_ADDRW-1:0]           node_cnt;
   logic [SLOT_W-1:0]               slot_cnt;
   logic [LEAF_ADDRW-1:0]           leaf_cnt;
   logic [QUERY_ADDRW-1:0]          query_cnt;
   logic                            node_last;
   logic                            slot_wrap;
   logic                            leaf_last;
   logic                            query_last;

   assign busy        = (state == NODES) || (state == LEAVES) || (state == QUERY);
   assign in_fifo_deq = busy && in_fifo_rempty_n;

   // A pop coinciding with load_kdtree leaves the FIFO but is thrown away.
   assign take = in_fifo_deq && !load_kdtree;

   assign asm_push   = take && ((state == LEAVES) || (state == QUERY));
   assign asm_nwords = (state == QUERY) ? 3'(PATCH_SIZE) : 3'(WORDS_PER_LEAF_PATCH);

   patch_assembler u_asm (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (asm_push),
      .clear  (load_kdtree),
      .nwords (asm_nwords),
      .data   (in_fifo_rdata),
      .patch  (asm_patch),
      .last   (asm_last)
   );

   assign node_last  = take && (state == NODES) && node_phase
                       && (node_cnt == LEAF_ADDRW'(NUM_LEAVES - 2));
   assign slot_wrap  = (slot_cnt == SLOT_W'(LEAF_SIZE - 1));
   assign leaf_last  = (state == LEAVES) && asm_last && slot_wrap
                       && (leaf_cnt == LEAF_ADDRW'(NUM_LEAVES - 1));
   assign query_last = (state == QUERY) && asm_last
                       && (query_cnt == QUERY_ADDRW'(NUM_QUERYS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (load_kdtree) begin
         state_nxt = NODES;
      end else begin
         case (state)
            NODES:   if (node_last)  state_nxt = LEAVES;
            LEAVES:  if (leaf_last)  state_nxt = QUERY;
            QUERY:   if (query_last) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         node_phase     <= 1'b0;
         idx_hold       <= '0;
         node_cnt       <= '0;
         slot_cnt       <= '0;
         leaf_cnt       <= '0;
         query_cnt      <= '0;
         node_wen       <= 1'b0;
         node_waddr     <= '0;
         node_idx       <= '0;
         node_median    <= '0;
         leaf_wen       <= 1'b0;
         leaf_waddr     <= '0;
         leaf_slot      <= '0;
         leaf_wpatch    <= '0;
         leaf_widx      <= '0;
         query_wen      <= 1'b0;
         query_waddr    <= '0;
         query_wpatch   <= '0;
         kdtree_loaded  <= 1'b0;
         queries_loaded <= 1'b0;
         cfg_err        <= 1'b0;
      end else begin
         node_wen  <= 1'b0;
         leaf_wen  <= 1'b0;
         query_wen <= 1'b0;
         if (load_kdtree) begin
            node_phase     <= 1'b0;
            idx_hold       <= '0;
            node_cnt       <= '0;
            slot_cnt       <= '0;
            leaf_cnt       <= '0;
            query_cnt      <= '0;
            kdtree_loaded  <= 1'b0;
            queries_loaded <= 1'b0;
            cfg_err        <= 1'b0;
         end else if (take) begin
            case (state)
               NODES: begin
                  if (!node_phase) begin
                     idx_hold   <= in_fifo_rdata[2:0];
                     node_phase <= 1'b1;
                     if (in_fifo_rdata >= DATA_WIDTH'(PATCH_SIZE)) begin
                        cfg_err <= 1'b1;
                     end
                  end else begin
                     node_wen    <= 1'b1;
                     node_waddr  <= node_cnt;
                     node_idx    <= idx_hold;
                     node_median <= in_fifo_rdata;
                     node_phase  <= 1'b0;
                     node_cnt    <= node_cnt + LEAF_ADDRW'(1);
                  end
               end
               LEAVES: begin
                  if (asm_last) begin
                     leaf_wen    <= 1'b1;
                     leaf_waddr  <= leaf_cnt;
                     leaf_slot   <= slot_cnt;
                     leaf_wpatch <= asm_patch;
                     leaf_widx   <= in_fifo_rdata[IDX_WIDTH-1:0];
                     slot_cnt    <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
                     if (slot_wrap) begin
                        leaf_cnt <= leaf_cnt + LEAF_ADDRW'(1);
                     end
                     if (leaf_last) begin
                        kdtree_loaded <= 1'b1;
                     end
                  end
               end
               QUERY: begin
                  if (asm_last) begin
                     query_wen    <= 1'b1;
                     query_waddr  <= query_cnt;
                     query_wpatch <= asm_patch;
                     query_cnt    <= query_cnt + QUERY_ADDRW'(1);
                     if (query_last) begin
                        queries_loaded <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// Bench for kdtree_load_ctrl: a FIFO queue feeds the DUT, and a word-index
// model (position of each popped word within the load stream) predicts
// every output on every cycle.
module tb_kdtree_load_ctrl;
   import kd_pkg::*;

   localparam int TOTAL = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;
   localparam int PW    = PATCH_SIZE * DATA_WIDTH;

   logic clk = 1'b0;
   logic rst_n;
   logic load_kdtree = 1'b0;
   logic in_fifo_rempty_n = 1'b0;
   logic [DATA_WIDTH-1:0] in_fifo_rdata = '0;
   logic in_fifo_deq;
   logic node_wen;
   logic [LEAF_ADDRW-1:0] node_waddr;
   logic [2:0] node_idx;
   logic [DATA_WIDTH-1:0] node_median;
   logic leaf_wen;
   logic [LEAF_ADDRW-1:0] leaf_waddr;
   logic [SLOT_W-1:0] leaf_slot;
   logic [PW-1:0] leaf_wpatch;
   logic [IDX_WIDTH-1:0] leaf_widx;
   logic query_wen;
   logic [QUERY_ADDRW-1:0] query_waddr;
   logic [PW-1:0] query_wpatch;
   logic busy, kdtree_loaded, queries_loaded, cfg_err;

   kdtree_load_ctrl dut (
      .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree),
      .in_fifo_rempty_n(in_fifo_rempty_n), .in_fifo_rdata(in_fifo_rdata),
      .in_fifo_deq(in_fifo_deq),
      .node_wen(node_wen), .node_waddr(node_waddr), .node_idx(node_idx),
      .node_median(node_median),
      .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_slot(leaf_slot),
      .leaf_wpatch(leaf_wpatch), .leaf_widx(leaf_widx),
      .query_wen(query_wen), .query_waddr(query_waddr), .query_wpatch(query_wpatch),
      .busy(busy), .kdtree_loaded(kdtree_loaded), .queries_loaded(queries_loaded),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- FIFO ----------------
   logic [DATA_WIDTH-1:0] fifo[$];
   logic do_pop = 1'b0;
   int   stall_mode = 0;
   int   cyc = 0;
   logic stall;

   always @(posedge clk) begin
      #1;
      if (do_pop && fifo.size() > 0) fifo.delete(0);
      cyc++;
      if (stall_mode == 1)      stall = ((cyc / 3) % 2) == 1;
      else if (stall_mode == 2) stall = ($urandom_range(0, 3) == 0);
      else                      stall = 1'b0;
      in_fifo_rempty_n = (fifo.size() > 0) && !stall;
      in_fifo_rdata    = (fifo.size() > 0) ? fifo[0] : '0;
   end

   // ---------------- model ----------------
   int   hist[TOTAL];
   int   pos = 0;
   bit   m_active = 0;
   logic e_deq;
   logic e_node_wen, e_leaf_wen, e_query_wen;
   logic [LEAF_ADDRW-1:0] e_node_waddr, e_leaf_waddr;
   logic [2:0] e_node_idx;
   logic [DATA_WIDTH-1:0] e_node_median;
   logic [SLOT_W-1:0] e_leaf_slot;
   logic [PW-1:0] e_leaf_wpatch, e_query_wpatch;
   logic [IDX_WIDTH-1:0] e_leaf_widx;
   logic [QUERY_ADDRW-1:0] e_query_waddr;
   logic e_kl, e_ql, e_cfg;

   task automatic model_reset();
      m_active = 0; pos = 0;
      e_node_wen = 0; e_leaf_wen = 0; e_query_wen = 0;
      e_node_waddr = '0; e_node_idx = '0; e_node_median = '0;
      e_leaf_waddr = '0; e_leaf_slot = '0; e_leaf_wpatch = '0; e_leaf_widx = '0;
      e_query_waddr = '0; e_query_wpatch = '0;
      e_kl = 0; e_ql = 0; e_cfg = 0;
   endtask

   // monitor captures for literal checks
   int n_node = 0, n_leaf = 0, n_query = 0, n_deq = 0;
   int med5 = -1, last_naddr = -1, first_naddr = -1, last_qaddr = -1, q10w0 = -1;
   int fin_seen = 0, fin_widx = -1, fin_kl = -1, fin_p0 = -1, fin_p4 = -1;

   always @(negedge clk) begin
      int k, j, p;
      if (!rst_n) model_reset();
      e_deq = m_active && in_fifo_rempty_n;
      chk("deq", in_fifo_deq, e_deq);
      chk("busy", busy, m_active);
      chk("node_wen", node_wen, e_node_wen);
      chk("node_waddr", node_waddr, e_node_waddr);
      chk("node_idx", node_idx, e_node_idx);
      chk("node_median", node_median, e_node_median);
      chk("leaf_wen", leaf_wen, e_leaf_wen);
      chk("leaf_waddr", leaf_waddr, e_leaf_waddr);
      chk("leaf_slot", leaf_slot, e_leaf_slot);
      chk("leaf_wpatch", leaf_wpatch, e_leaf_wpatch);
      chk("leaf_widx", leaf_widx, e_leaf_widx);
      chk("query_wen", query_wen, e_query_wen);
      chk("query_waddr", query_waddr, e_query_waddr);
      chk("query_wpatch", query_wpatch, e_query_wpatch);
      chk("kdtree_loaded", kdtree_loaded, e_kl);
      chk("queries_loaded", queries_loaded, e_ql);
      chk("cfg_err", cfg_err, e_cfg);

      if (in_fifo_deq) n_deq++;
      if (node_wen) begin
         n_node++;
         last_naddr = int'(node_waddr);
         if (first_naddr < 0) first_naddr = int'(node_waddr);
         if (node_waddr == 5) med5 = int'(node_median);
      end
      if (leaf_wen) begin
         n_leaf++;
         if (leaf_waddr == LEAF_ADDRW'(NUM_LEAVES - 1) && leaf_slot == SLOT_W'(LEAF_SIZE - 1)) begin
            fin_seen = 1; fin_widx = int'(leaf_widx); fin_kl = int'(kdtree_loaded);
            fin_p0 = int'(leaf_wpatch[DATA_WIDTH-1:0]);
            fin_p4 = int'(leaf_wpatch[PW-1 -: DATA_WIDTH]);
         end
      end
      if (query_wen) begin
         n_query++;
         last_qaddr = int'(query_waddr);
         if (query_waddr == 10) q10w0 = int'(query_wpatch[DATA_WIDTH-1:0]);
      end

      do_pop = in_fifo_deq;

      e_node_wen = 0; e_leaf_wen = 0; e_query_wen = 0;
      if (rst_n) begin
         if (load_kdtree) begin
            m_active = 1; pos = 0; e_kl = 0; e_ql = 0; e_cfg = 0;
         end else if (e_deq) begin
            k = pos; hist[k] = int'(in_fifo_rdata); pos++;
            if (k < NODE_WORDS) begin
               if (k % 2 == 0) begin
                  if (int'(in_fifo_rdata) >= PATCH_SIZE) e_cfg = 1;
               end else begin
                  e_node_wen = 1; e_node_waddr = LEAF_ADDRW'(k / 2);
                  e_node_idx = 3'(hist[k-1] & 7); e_node_median = in_fifo_rdata;
               end
            end else if (k < NODE_WORDS + LEAF_WORDS) begin
               j = k - NODE_WORDS;
               if (j % WORDS_PER_LEAF_PATCH == PATCH_SIZE) begin
                  p = j / WORDS_PER_LEAF_PATCH;
                  e_leaf_wen = 1; e_leaf_waddr = LEAF_ADDRW'(p / LEAF_SIZE);
                  e_leaf_slot = SLOT_W'(p % LEAF_SIZE);
                  for (int w = 0; w < PATCH_SIZE; w++)
                     e_leaf_wpatch[w*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(hist[k-PATCH_SIZE+w]);
                  e_leaf_widx = IDX_WIDTH'(in_fifo_rdata);
                  if (k == NODE_WORDS + LEAF_WORDS - 1) e_kl = 1;
               end
            end else begin
               j = k - NODE_WORDS - LEAF_WORDS;
               if (j % PATCH_SIZE == PATCH_SIZE - 1) begin
                  e_query_wen = 1; e_query_waddr = QUERY_ADDRW'(j / PATCH_SIZE);
                  for (int w = 0; w < PATCH_SIZE; w++)
                     e_query_wpatch[w*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(hist[k-PATCH_SIZE+1+w]);
                  if (k == TOTAL - 1) e_ql = 1;
               end
            end
            if (pos == TOTAL) m_active = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_load();
      load_kdtree = 1'b1;
      step(1);
      load_kdtree = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (fifo.size() != 0 && n < budget) begin step(1); n++; end
      chk(nm, fifo.size(), 0);
      step(3);
   endtask

   task automatic push_w(input int v);
      fifo.push_back(DATA_WIDTH'(v));
   endtask

   task automatic clear_mon();
      n_node = 0; n_leaf = 0; n_query = 0; n_deq = 0;
      med5 = -1; last_naddr = -1; first_naddr = -1; last_qaddr = -1; q10w0 = -1;
      fin_seen = 0; fin_widx = -1; fin_kl = -1; fin_p0 = -1; fin_p4 = -1;
   endtask

   // mode 0: plan values, 1: idx 7 first then random, 2: random legal idx
   task automatic push_nodes(input int mode);
      for (int n = 0; n < NUM_LEAVES - 1; n++) begin
         if (mode == 0)      push_w(2);
         else if (mode == 1) push_w(n == 0 ? 7 : int'($urandom_range(0, 7)));
         else                push_w(int'($urandom_range(0, PATCH_SIZE - 1)));
         push_w(mode == 0 ? 100 + n : int'($urandom_range(0, 2047)));
      end
   endtask

   task automatic push_leaves(input int mode);
      for (int p = 0; p < NUM_LEAVES * LEAF_SIZE; p++) begin
         for (int w = 0; w < PATCH_SIZE; w++)
            push_w(mode == 0 ? p : int'($urandom_range(0, 2047)));
         push_w(mode == 0 ? 300 : int'($urandom_range(0, 2047)));
      end
   endtask

   task automatic push_queries(input int mode, input int nq);
      for (int q = 0; q < nq; q++)
         for (int w = 0; w < PATCH_SIZE; w++)
            push_w(mode == 0 ? ((q * PATCH_SIZE + w) & 2047) : int'($urandom_range(0, 2047)));
   endtask

   initial begin
      int n;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_deq", in_fifo_deq, 0);
      chk("rst_flags", {kdtree_loaded, queries_loaded, cfg_err}, 0);
      chk("rst_wens", {node_wen, leaf_wen, query_wen}, 0);
      rst_n = 1'b1;
      step(2);

      // 1: nodes
      clear_mon();
      pulse_load();
      push_nodes(0);
      drain("t1_drain", 400);
      chk("t1_node_count", n_node, 63);
      chk("t1_last_naddr", last_naddr, 62);
      chk("t1_node5_median", med5, 105);
      chk("t1_cfg_err", cfg_err, 0);

      // 2: leaves
      clear_mon();
      push_leaves(0);
      drain("t2_drain", 4000);
      chk("t2_leaf_count", n_leaf, 512);
      chk("t2_final_seen", fin_seen, 1);
      chk("t2_final_widx", fin_widx, 300);
      chk("t2_final_kl_with_wen", fin_kl, 1);
      chk("t2_final_word0", fin_p0, 511);
      chk("t2_final_word4", fin_p4, 511);

      // 3: queries with periodic stalls
      clear_mon();
      stall_mode = 1;
      push_queries(0, NUM_QUERYS);
      drain("t3_drain", 8000);
      stall_mode = 0;
      chk("t3_query_count", n_query, 494);
      chk("t3_last_qaddr", last_qaddr, 493);
      chk("t3_q10_word0", q10w0, 50);
      chk("t3_queries_loaded", queries_loaded, 1);
      chk("t3_busy", busy, 0);
      chk("t3_kdtree_loaded", kdtree_loaded, 1);

      // 4: restart mid leaf patch, last pop coinciding with load
      pulse_load();
      push_nodes(0);
      for (int w = 0; w < 3; w++) push_w(40 + w);
      drain("t4_drain_a", 400);
      clear_mon();
      for (int w = 0; w < 3; w++) push_w(50 + w);
      step(3);
      load_kdtree = 1'b1;
      step(1);
      load_kdtree = 1'b0;
      step(4);
      chk("t4_no_leaf_wen", n_leaf, 0);
      chk("t4_kdtree_loaded", kdtree_loaded, 0);
      chk("t4_busy_nodes", busy, 1);
      chk("t4_fifo_consumed", fifo.size(), 0);
      push_w(1); push_w(9);
      drain("t4_drain_b", 50);
      chk("t4_node_count", n_node, 1);
      chk("t4_first_naddr", first_naddr, 0);

      // 5: bad split dim, random data and random stalls through DONE
      pulse_load();
      stall_mode = 2;
      push_nodes(1);
      push_leaves(1);
      push_queries(1, NUM_QUERYS);
      drain("t5_drain", 12000);
      stall_mode = 0;
      step(5);
      chk("t5_cfg_err_done", cfg_err, 1);
      chk("t5_queries_loaded", queries_loaded, 1);
      chk("t5_busy", busy, 0);
      pulse_load();
      chk("t5_cfg_err_cleared", cfg_err, 0);
      chk("t5_busy_again", busy, 1);

      // 6: async reset mid-QUERY
      push_nodes(2);
      push_leaves(2);
      push_queries(1, 20);
      n = 0;
      while (fifo.size() > 40 && n < 5000) begin step(1); n++; end
      chk("t6_reach_query", fifo.size() <= 40, 1);
      chk("t6_kl_before", kdtree_loaded, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_busy", busy, 0);
      chk("t6_async_deq", in_fifo_deq, 0);
      chk("t6_async_flags", {kdtree_loaded, queries_loaded, cfg_err}, 0);
      chk("t6_async_wens", {node_wen, leaf_wen, query_wen}, 0);
      chk("t6_async_data", {leaf_wpatch, node_median}, 0);
      chk("t6_async_addr", {query_waddr, leaf_waddr, leaf_slot, node_waddr}, 0);
      step(3);
      fifo.delete();
      for (int w = 0; w < 5; w++) push_w(w);
      step(2);
      rst_n = 1'b1;
      clear_mon();
      step(10);
      chk("t6_no_pops", n_deq, 0);
      chk("t6_fifo_kept", fifo.size(), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kdtree_load_ctrl.md
Name: kdtree_load_ctrl

Overview:
- Sequences the shared input FIFO word stream into the design's three storage targets after a `load_kdtree` pulse: internal-node registers, leaf memory, then query-patch memory.
- Assembles multi-word records (node = idx+median, leaf patch = 5 data + 1 index, query = 5 data) and issues one wide write per record.
- Sits on the core-clock side of the input async FIFO, ahead of the search FSM; its done flags gate `fsm_start`.

Parameters:
- DATA_WIDTH, 11, width of one FIFO word and one patch element
- IDX_WIDTH, 9, width of a leaf patch's original-image index
- PATCH_SIZE, 5, data words per patch
- LEAF_SIZE, 8, patches per leaf
- NUM_LEAVES, 64, leaves in the tree; internal nodes = NUM_LEAVES-1
- NUM_QUERYS, 494, query patches per frame
- LEAF_ADDRW, $clog2(NUM_LEAVES), leaf/node address width
- QUERY_ADDRW, $clog2(NUM_QUERYS), query address width

Ports:
- clk  in  1  core clock; the single clock of the block
- rst_n  in  1  asynchronous, active-low reset
- load_kdtree  in  1  one-cycle start pulse; restarts the whole sequence
- in_fifo_rempty_n  in  1  FIFO non-empty (first-word-fall-through)
- in_fifo_rdata  in  DATA_WIDTH  FIFO head word
- in_fifo_deq  out  1  pop the FIFO head this cycle
- node_wen  out  1  internal-node write strobe
- node_waddr  out  LEAF_ADDRW  node number, 0..NUM_LEAVES-2
- node_idx  out  3  split dimension
- node_median  out  DATA_WIDTH  split value
- leaf_wen  out  1  leaf-patch write strobe
- leaf_waddr  out  LEAF_ADDRW  leaf number
- leaf_slot  out  $clog2(LEAF_SIZE)  patch slot within the leaf
- leaf_wpatch  out  PATCH_SIZE*DATA_WIDTH  patch data; word 0 in the LSBs
- leaf_widx  out  IDX_WIDTH  patch's original-image index
- query_wen  out  1  query-patch write strobe
- query_waddr  out  QUERY_ADDRW  query number
- query_wpatch  out  PATCH_SIZE*DATA_WIDTH  query data; word 0 in the LSBs
- busy  out  1  high in NODES, LEAVES or QUERY
- kdtree_loaded  out  1  sticky; all nodes and leaves written
- queries_loaded  out  1  sticky; all queries written
- cfg_err  out  1  sticky; a node idx word had value >= PATCH_SIZE

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and assembly registers 0.
- States: IDLE -> NODES -> LEAVES -> QUERY -> DONE.
  - load_kdtree in any state -> NODES in the next cycle.
  - Clears all counters and the three sticky flags.
  - A partially assembled record is discarded; no write is issued for it.
  - A FIFO pop in the same cycle as load_kdtree is still consumed, but is discarded.
- Dequeue: in_fifo_deq = (state is NODES, LEAVES or QUERY) && in_fifo_rempty_n, combinational.
  - in_fifo_rdata is consumed in the same cycle as the pop.
  - No pops in IDLE or DONE; the FIFO retains its words.
- NODES: 2*(NUM_LEAVES-1) words.
  - Even word = idx; bits [2:0] are kept and cfg_err is set if the value >= PATCH_SIZE.
  - Odd word = median.
  - After the median pop: node_wen=1 for exactly 1 cycle, next cycle (registered), with node_waddr = node count.
  - The last median moves the state to LEAVES.
- LEAVES: NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words, grouped 6 per patch.
  - Words 0..4 shift into leaf_wpatch slot k.
  - Word 5 = index; bits [IDX_WIDTH-1:0] go to leaf_widx.
  - leaf_wen pulses 1 cycle after the index pop.
  - leaf_slot increments per patch and wraps LEAF_SIZE-1 -> 0; leaf_waddr increments on that wrap.
  - The final patch sets kdtree_loaded in the same cycle as its leaf_wen and moves to QUERY.
- QUERY: NUM_QUERYS*PATCH_SIZE words.
  - query_wen pulses 1 cycle after each 5th word; query_waddr increments per patch.
  - The final patch sets queries_loaded, moves to DONE and drops busy.
- Throughput: one word per cycle with no bubbles; the write pulse overlaps the next record's first pop.
- FIFO empty mid-record: word counters hold and assembled words are kept; there is no timeout.
- Data/address outputs hold their last written values between strobes.
- At most one *_wen is high in any cycle.

Decomposition:
- Shared package `kd_pkg` holds:
  - state enum: IDLE, NODES, LEAVES, QUERY, DONE
  - localparams: NODE_WORDS, LEAF_WORDS, QUERY_WORDS, WORDS_PER_LEAF_PATCH=PATCH_SIZE+1
  - patch_t: packed PATCH_SIZE x DATA_WIDTH
- One sub-module, `patch_assembler`: word shift register plus word counter, with inputs push, clear and nwords and outputs patch and last.
  - Instantiated once and shared across LEAVES and QUERY.
  - nwords = 6 in LEAVES, 5 in QUERY.

Test Plan:
1. Reset, then pulse load_kdtree; stream 126 node words idx=2, median=100+n -> 63 node_wen pulses, node_waddr 0..62, node 5 has median 105, cfg_err=0.
2. Stream 3072 leaf words with patch data = leaf*8+slot and index = 300 -> leaf 63 slot 7 written with leaf_widx=300; kdtree_loaded rises with that final leaf_wen.
3. Stream 2470 query words with in_fifo_rempty_n toggled every 3 cycles -> 494 query_wen pulses, query_waddr 493 last, query 10 word 0 = 50 intact despite stalls; queries_loaded=1, busy=0.
4. Pulse load_kdtree after 3 words of a leaf patch -> no leaf_wen for the partial patch, state NODES, kdtree_loaded=0; next node write has node_waddr=0.
5. Node idx word = 7 -> cfg_err=1 and remains set through DONE; cleared by the next load_kdtree.
6. Assert rst_n low mid-QUERY -> all outputs 0 immediately (asynchronous); no pops until the next load_kdtree.
